// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared encodings and defaults for the pipeline sequencing controller
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } pipe_state_t;

    localparam int RNBITS_DEF       = 5;
    localparam int DRAIN_CYCLES_DEF = 4;
    localparam int SCNT_BITS_DEF    = 16;

endpackage

// File: rtl/detector_load_use.sv
// rtl/detector_load_use.sv - combinational load-use hazard compare between EX load and ID sources
module detector_load_use
    import pipeline_pkg::*;
#(
    parameter int RNBITS = RNBITS_DEF
) (
    input  logic              i_EX_MemRead,
    input  logic [RNBITS-1:0] i_EX_Rt,
    input  logic [RNBITS-1:0] i_ID_Rs,
    input  logic [RNBITS-1:0] i_ID_Rt,
    input  logic              i_ID_UsesRt,
    output logic              o_Load_Use
);

    // A load to $0 never produces a value worth waiting for.
    assign o_Load_Use = i_EX_MemRead && (i_EX_Rt != '0) &&
                        ((i_EX_Rt == i_ID_Rs) || (i_ID_UsesRt && (i_EX_Rt == i_ID_Rt)));

endmodule

// File: rtl/control_riesgos_pipeline.sv
// rtl/control_riesgos_pipeline.sv - hazard, flush, HALT drain and step gating for the 5-stage core
module control_riesgos_pipeline
    import pipeline_pkg::*;
#(
    parameter int RNBITS       = RNBITS_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int SCNT_BITS    = SCNT_BITS_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_Step_Mode,
    input  logic                 i_Step,
    input  logic [RNBITS-1:0]    i_ID_Rs,
    input  logic [RNBITS-1:0]    i_ID_Rt,
    input  logic                 i_ID_UsesRt,
    input  logic                 i_ID_Halt,
    input  logic                 i_EX_MemRead,
    input  logic [RNBITS-1:0]    i_EX_Rt,
    input  logic                 i_MEM_BranchTaken,
    input  logic                 i_EX_JumpTaken,
    output logic                 o_Pipe_Enable,
    output logic                 o_PC_Write,
    output logic                 o_IF_ID_Write,
    output logic                 o_IF_ID_Flush,
    output logic                 o_ID_EX_Flush,
    output logic                 o_EX_MEM_Flush,
    output logic                 o_Halted,
    output logic [SCNT_BITS-1:0] o_Stall_Count
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

    pipe_state_t          state_q, state_d;
    logic [DCW-1:0]       drain_q, drain_d;
    logic [SCNT_BITS-1:0] scnt_q, scnt_d;
    logic                 en;
    logic                 lu;

    detector_load_use #(.RNBITS(RNBITS)) u_detector (
        .i_EX_MemRead (i_EX_MemRead),
        .i_EX_Rt      (i_EX_Rt),
        .i_ID_Rs      (i_ID_Rs),
        .i_ID_Rt      (i_ID_Rt),
        .i_ID_UsesRt  (i_ID_UsesRt),
        .o_Load_Use   (lu)
    );

    assign en = !i_Step_Mode || i_Step;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= RUN;
            drain_q <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            scnt_q  <= scnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        drain_d        = drain_q;
        scnt_d         = scnt_q;
        o_Pipe_Enable  = 1'b0;
        o_PC_Write     = 1'b0;
        o_IF_ID_Write  = 1'b0;
        o_IF_ID_Flush  = 1'b0;
        o_ID_EX_Flush  = 1'b0;
        o_EX_MEM_Flush = 1'b0;
        o_Halted       = 1'b0;

        if (!i_reset) begin
            o_IF_ID_Flush  = 1'b1;
            o_ID_EX_Flush  = 1'b1;
            o_EX_MEM_Flush = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    o_Pipe_Enable = en;
                    if (en) begin
                        // IF/ID write stays high on flushes so the register actually loads the zero.
                        if (i_MEM_BranchTaken) begin
                            o_PC_Write     = 1'b1;
                            o_IF_ID_Write  = 1'b1;
                            o_IF_ID_Flush  = 1'b1;
                            o_ID_EX_Flush  = 1'b1;
                            o_EX_MEM_Flush = 1'b1;
                        end else if (i_EX_JumpTaken) begin
                            o_PC_Write    = 1'b1;
                            o_IF_ID_Write = 1'b1;
                            o_IF_ID_Flush = 1'b1;
                            o_ID_EX_Flush = 1'b1;
                        end else if (lu) begin
                            o_ID_EX_Flush = 1'b1;
                            if (scnt_q != '1) begin
                                scnt_d = scnt_q + 1'b1;
                            end
                        end else if (i_ID_Halt) begin
                            o_IF_ID_Write = 1'b1;
                            o_IF_ID_Flush = 1'b1;
                            state_d       = DRAIN;
                            drain_d       = DRAIN_LAST;
                        end else begin
                            o_PC_Write    = 1'b1;
                            o_IF_ID_Write = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    o_Pipe_Enable = en;
                    if (en) begin
                        o_IF_ID_Write = 1'b1;
                        o_IF_ID_Flush = 1'b1;
                        if (drain_q == '0) begin
                            state_d = HALTED;
                        end else begin
                            drain_d = drain_q - 1'b1;
                        end
                    end
                end
                HALTED: begin
                    o_Halted = 1'b1;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign o_Stall_Count = scnt_q;

endmodule

// File: tb/tb_control_riesgos_pipeline.sv
// tb/tb_control_riesgos_pipeline.sv - directed self-checking bench for control_riesgos_pipeline
module tb_control_riesgos_pipeline;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_Step_Mode;
    logic        i_Step;
    logic [4:0]  i_ID_Rs;
    logic [4:0]  i_ID_Rt;
    logic        i_ID_UsesRt;
    logic        i_ID_Halt;
    logic        i_EX_MemRead;
    logic [4:0]  i_EX_Rt;
    logic        i_MEM_BranchTaken;
    logic        i_EX_JumpTaken;
    logic        o_Pipe_Enable;
    logic        o_PC_Write;
    logic        o_IF_ID_Write;
    logic        o_IF_ID_Flush;
    logic        o_ID_EX_Flush;
    logic        o_EX_MEM_Flush;
    logic        o_Halted;
    logic [15:0] o_Stall_Count;

    int checks = 0;
    int errors = 0;

    // {Pipe_Enable, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Halted}
    localparam logic [6:0] O_NORMAL = 7'b111_000_0;
    localparam logic [6:0] O_LU     = 7'b100_010_0;
    localparam logic [6:0] O_BRANCH = 7'b111_111_0;
    localparam logic [6:0] O_JUMP   = 7'b111_110_0;
    localparam logic [6:0] O_HALT   = 7'b101_100_0;
    localparam logic [6:0] O_IDLE   = 7'b000_000_0;
    localparam logic [6:0] O_HALTED = 7'b000_000_1;
    localparam logic [6:0] O_RESET  = 7'b000_111_0;

    control_riesgos_pipeline dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_Step_Mode       (i_Step_Mode),
        .i_Step            (i_Step),
        .i_ID_Rs           (i_ID_Rs),
        .i_ID_Rt           (i_ID_Rt),
        .i_ID_UsesRt       (i_ID_UsesRt),
        .i_ID_Halt         (i_ID_Halt),
        .i_EX_MemRead      (i_EX_MemRead),
        .i_EX_Rt           (i_EX_Rt),
        .i_MEM_BranchTaken (i_MEM_BranchTaken),
        .i_EX_JumpTaken    (i_EX_JumpTaken),
        .o_Pipe_Enable     (o_Pipe_Enable),
        .o_PC_Write        (o_PC_Write),
        .o_IF_ID_Write     (o_IF_ID_Write),
        .o_IF_ID_Flush     (o_IF_ID_Flush),
        .o_ID_EX_Flush     (o_ID_EX_Flush),
        .o_EX_MEM_Flush    (o_EX_MEM_Flush),
        .o_Halted          (o_Halted),
        .o_Stall_Count     (o_Stall_Count)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        #1;
        obs = {o_Pipe_Enable, o_PC_Write, o_IF_ID_Write, o_IF_ID_Flush,
               o_ID_EX_Flush, o_EX_MEM_Flush, o_Halted};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] exp);
        checks++;
        assert (o_Stall_Count === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, o_Stall_Count, exp);
        end
    endtask

    task automatic clear_inputs();
        i_ID_Rs = 5'd0; i_ID_Rt = 5'd0; i_ID_UsesRt = 1'b0; i_ID_Halt = 1'b0;
        i_EX_MemRead = 1'b0; i_EX_Rt = 5'd0;
        i_MEM_BranchTaken = 1'b0; i_EX_JumpTaken = 1'b0;
    endtask

    initial begin
        i_reset = 1'b0; i_Step_Mode = 1'b0; i_Step = 1'b0;
        clear_inputs();

        chk_out("reset_outputs", O_RESET);
        tick(); tick();
        chk_cnt("reset_stall_count", 16'd0);
        i_reset = 1'b1;
        chk_out("run_normal", O_NORMAL);
        tick();

        // lw $2 in EX, add $3,$2,$4 in ID
        i_EX_MemRead = 1'b1; i_EX_Rt = 5'd2; i_ID_Rs = 5'd2; i_ID_Rt = 5'd4; i_ID_UsesRt = 1'b1;
        chk_out("load_use_stall", O_LU);
        chk_cnt("stall_count_before", 16'd0);
        tick();
        clear_inputs();
        chk_out("after_stall_normal", O_NORMAL);
        chk_cnt("stall_count_after", 16'd1);
        tick();

        i_EX_MemRead = 1'b1; i_EX_Rt = 5'd0; i_ID_Rs = 5'd0;
        chk_out("load_to_r0_no_stall", O_NORMAL);
        i_EX_Rt = 5'd5; i_ID_Rs = 5'd1; i_ID_Rt = 5'd5; i_ID_UsesRt = 1'b0;
        chk_out("rt_match_unused_no_stall", O_NORMAL);
        i_ID_UsesRt = 1'b1;
        chk_out("rt_match_used_stall", O_LU);
        clear_inputs();
        tick();
        chk_cnt("no_stall_count_change", 16'd1);

        // branch beats load-use and HALT
        i_MEM_BranchTaken = 1'b1; i_ID_Halt = 1'b1;
        i_EX_MemRead = 1'b1; i_EX_Rt = 5'd7; i_ID_Rs = 5'd7;
        chk_out("branch_priority", O_BRANCH);
        tick();
        clear_inputs();
        chk_out("after_branch_run", O_NORMAL);
        chk_cnt("branch_no_stall_count", 16'd1);

        i_EX_JumpTaken = 1'b1; i_ID_Halt = 1'b1;
        chk_out("jump_priority", O_JUMP);
        tick();
        clear_inputs();
        chk_out("after_jump_run", O_NORMAL);

        // load-use holds HALT in ID, HALT taken next cycle
        i_ID_Halt = 1'b1; i_EX_MemRead = 1'b1; i_EX_Rt = 5'd3; i_ID_Rs = 5'd3;
        chk_out("lu_over_halt", O_LU);
        tick();
        i_EX_MemRead = 1'b0;
        chk_cnt("lu_over_halt_count", 16'd2);
        chk_out("halt_run_cycle", O_HALT);
        tick();
        i_ID_Halt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                i_MEM_BranchTaken = 1'b1; i_EX_JumpTaken = 1'b1;
                i_EX_MemRead = 1'b1; i_EX_Rt = 5'd9; i_ID_Rs = 5'd9;
            end else begin
                clear_inputs();
            end
            chk_out($sformatf("drain_cycle_%0d", k), O_HALT);
            tick();
        end
        clear_inputs();
        chk_out("halted_t_plus_5", O_HALTED);
        chk_cnt("drain_ignores_lu", 16'd2);
        i_MEM_BranchTaken = 1'b1; i_ID_Halt = 1'b1;
        tick();
        chk_out("halted_sticky_branch", O_HALTED);
        tick();
        clear_inputs();
        chk_out("halted_sticky", O_HALTED);

        i_reset = 1'b0;
        chk_out("reset_from_halted", O_RESET);
        tick();
        i_reset = 1'b1;
        chk_out("run_after_reset", O_NORMAL);
        chk_cnt("stall_count_cleared", 16'd0);

        // step mode: HALT needs 5 enabled cycles, idle cycles are fully gated
        i_Step_Mode = 1'b1; i_ID_Halt = 1'b1;
        for (int p = 0; p < 5; p++) begin
            for (int q = 0; q < 2; q++) begin
                i_Step = 1'b0;
                if (q == 1) begin
                    i_EX_MemRead = 1'b1; i_EX_Rt = 5'd6; i_ID_Rs = 5'd6;
                end
                chk_out($sformatf("step_idle_%0d_%0d", p, q), O_IDLE);
                tick();
                i_EX_MemRead = 1'b0;
            end
            i_Step = 1'b1;
            chk_out($sformatf("step_pulse_%0d", p), O_HALT);
            tick();
            i_Step = 1'b0;
            i_ID_Halt = 1'b0;
        end
        chk_out("step_halted", O_HALTED);
        chk_cnt("step_stall_count_held", 16'd0);

        // reset mid-drain
        i_reset = 1'b0; i_Step_Mode = 1'b0;
        tick();
        i_reset = 1'b1; i_ID_Halt = 1'b1;
        chk_out("halt_before_mid_reset", O_HALT);
        tick();
        clear_inputs();
        tick(); tick();
        chk_out("mid_drain", O_HALT);
        i_reset = 1'b0;
        chk_out("reset_in_drain", O_RESET);
        tick();
        i_reset = 1'b1;
        chk_out("run_after_drain_reset", O_NORMAL);
        chk_cnt("count_after_drain_reset", 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
